// File: rtl/led_pattern_gen_if.sv
// led_pattern_gen_if: control and display signals of the LED pattern generator
// master: drives mode/run/step, observes leds/tick
// slave:  the generator itself
interface led_pattern_gen_if #(
  parameter int WIDTH = 8
);
  logic [1:0]       mode;
  logic             run;
  logic             step;
  logic [WIDTH-1:0] leds;
  logic             tick;
  modport master(output mode, run, step, input leds, tick);
  modport slave(input mode, run, step, output leds, tick);
endinterface

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: WIDTH-bit LED pattern (up/down/scanner/Gray) advanced at TICK_HZ or by single step
// clk   : system clock
// rst_n : synchronous active-low reset
// bus   : mode/run/step in, registered leds and one-cycle tick out
module led_pattern_gen #(
  parameter int CLK_FREQ = 25_000_000,
  parameter int TICK_HZ  = 2,
  parameter int WIDTH    = 8
) (
  input logic               clk,
  input logic               rst_n,
  led_pattern_gen_if.slave  bus
);
  localparam int DIV = (CLK_FREQ / TICK_HZ) < 1 ? 1 : CLK_FREQ / TICK_HZ;
  localparam logic [31:0] LAST = 32'(DIV - 1);
  logic [31:0]      pcnt_q, pcnt_d;
  logic [WIDTH-1:0] cnt_q, cnt_d, leds_q, leds_d;
  logic [WIDTH-1:0] start_cnt, start_leds, up_n, dn_n, scan_n;
  logic [1:0]       mode_q;
  logic             dir_q, dir_d, tick_q, step_q, mode_chg, adv, wrap;
  always_comb begin
    mode_chg   = bus.mode != mode_q;
    wrap       = bus.run && pcnt_q == LAST;
    adv        = !mode_chg && (wrap || (!bus.run && bus.step && !step_q));
    start_cnt  = bus.mode == 2'd1 ? '1 : '0;
    start_leds = bus.mode == 2'd1 ? '1 : bus.mode == 2'd2 ? WIDTH'(1) : '0;
    up_n       = cnt_q + WIDTH'(1);
    dn_n       = cnt_q - WIDTH'(1);
    scan_n     = dir_q ? leds_q >> 1 : leds_q << 1;
    pcnt_d     = mode_chg || wrap ? '0 : bus.run ? pcnt_q + 32'd1 : pcnt_q;
    cnt_d      = mode_chg ? start_cnt : !adv ? cnt_q :
                 mode_q == 2'd1 ? dn_n : mode_q == 2'd2 ? cnt_q : up_n;
    leds_d     = mode_chg ? start_leds : !adv ? leds_q :
                 mode_q == 2'd0 ? up_n : mode_q == 2'd1 ? dn_n :
                 mode_q == 2'd2 ? scan_n : up_n ^ (up_n >> 1);
    // direction flips only when the lit bit lands on an end
    dir_d      = mode_chg ? 1'b0 : !(adv && mode_q == 2'd2) ? dir_q :
                 dir_q ? !scan_n[0] : scan_n[WIDTH-1];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pcnt_q <= '0;
      tick_q <= 1'b0;
      step_q <= 1'b0;
      mode_q <= bus.mode;
      cnt_q  <= start_cnt;
      leds_q <= start_leds;
      dir_q  <= 1'b0;
    end else begin
      pcnt_q <= pcnt_d;
      tick_q <= adv;
      step_q <= bus.step;
      mode_q <= bus.mode;
      cnt_q  <= cnt_d;
      leds_q <= leds_d;
      dir_q  <= dir_d;
    end
  end
  assign bus.leds = leds_q;
  assign bus.tick = tick_q;
endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen: scoreboard bench for led_pattern_gen with a sequence-index reference model
module tb_led_pattern_gen;
  localparam int W   = 4;
  localparam int DIV = 4;
  typedef struct {int cyc; logic [W-1:0] leds;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  led_pattern_gen_if #(.WIDTH(W)) bus();
  led_pattern_gen #(.CLK_FREQ(8), .TICK_HZ(2), .WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  always #5 clk = ~clk;
  exp_t sb[$];
  int n_checks = 0, n_err = 0;
  int cyc = 0, m = 0, k = 0, ph = 0, tick_cnt = 0;
  bit sp = 0, fire = 0, started = 0;
  task automatic chk(string nm, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  // expected pattern after k advances from the start value of mode md
  function automatic logic [W-1:0] seq(int md, int kk);
    int p;
    case (md)
      0: return W'(kk % 16);
      1: return W'(15 - kk % 16);
      2: begin p = kk % 6; return W'(1 << (p < 4 ? p : 6 - p)); end
      default: begin p = kk % 16; return W'(p ^ (p >> 1)); end
    endcase
  endfunction
  // reference model: k counts advances since the last start, ph counts cycles since the last advance
  always @(posedge clk) begin
    cyc++;
    fire = 0;
    if (!rst_n) begin
      m = bus.mode; k = 0; ph = 0; sp = 0; started = 1;
    end else if (bus.mode != m) begin
      m = bus.mode; k = 0; ph = 0; sp = bus.step;
    end else begin
      if (bus.run) begin
        if (ph == DIV - 1) begin ph = 0; fire = 1; end else ph++;
      end else fire = bus.step && !sp;
      sp = bus.step;
      if (fire) begin
        k++;
        sb.push_back('{cyc, seq(m, k)});
      end
    end
  end
  always @(negedge clk) begin
    exp_t e;
    if (started) begin
      chk("leds_track", bus.leds, seq(m, k));
      chk("tick_track", bus.tick, fire);
      if (bus.tick) begin
        tick_cnt++;
        if (sb.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL sb_unexpected_tick: got tick with leds %0h, expected no tick (cycle %0d)", bus.leds, cyc);
        end else begin
          e = sb.pop_front();
          chk("sb_tick_cycle", cyc, e.cyc);
          chk("sb_leds", bus.leds, e.leds);
        end
      end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        chk("sb_missing_tick", bus.tick, 1);
      end
    end
  end
  task automatic tk(int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask
  task automatic wait_tick(output int n);
    for (n = 1; n <= 12; n++) begin
      tk(1);
      if (bus.tick) return;
    end
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "timeout");
  end
  initial begin
    int n, t;
    logic [W-1:0] prev;
    int scan_exp[8] = '{1, 2, 4, 8, 4, 2, 1, 2};
    int gray_exp[17] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8, 0};
    bus.mode = 2'd1; bus.run = 1'b0; bus.step = 1'b0;
    tk(2);
    chk("reset_down_leds", bus.leds, 4'hf);
    chk("reset_tick", bus.tick, 0);
    bus.mode = 2'd2;
    tk(1);
    chk("reset_scan_leds", bus.leds, 4'h1);
    rst_n = 1'b1;
    bus.mode = 2'd0; bus.run = 1'b1;
    tk(1);
    chk("up_start", bus.leds, 0);
    t = 0;
    for (int i = 0; i < 64; i++) begin
      tk(1);
      t += int'(bus.tick);
    end
    chk("up_tick_count", t, 16);
    chk("up_wrap_leds", bus.leds, 0);
    for (int i = 0; i < 40; i++) begin
      tk(1);
      if (bus.tick && bus.leds == 4'd5) break;
    end
    chk("up_reach5", bus.leds, 5);
    tk(2);
    bus.mode = 2'd1;
    tk(1);
    chk("mchg_leds", bus.leds, 4'hf);
    chk("mchg_tick", bus.tick, 0);
    wait_tick(n);
    chk("mchg_gap", n, 4);
    chk("mchg_first_dec", bus.leds, 4'he);
    tk(2);
    rst_n = 1'b0;
    tk(1);
    chk("midrst_leds", bus.leds, 4'hf);
    chk("midrst_tick", bus.tick, 0);
    rst_n = 1'b1;
    wait_tick(n);
    chk("midrst_gap", n, 4);
    chk("midrst_dec", bus.leds, 4'he);
    bus.mode = 2'd2;
    tk(1);
    chk("scan_start", bus.leds, scan_exp[0]);
    for (int i = 1; i < 8; i++) begin
      wait_tick(n);
      chk("scan_gap", n, 4);
      chk("scan_leds", bus.leds, scan_exp[i]);
    end
    bus.mode = 2'd3;
    tk(1);
    chk("gray_start", bus.leds, gray_exp[0]);
    prev = bus.leds;
    for (int i = 1; i < 17; i++) begin
      wait_tick(n);
      chk("gray_leds", bus.leds, gray_exp[i]);
      chk("gray_onebit", $countones(bus.leds ^ prev), 1);
      prev = bus.leds;
    end
    bus.run = 1'b0; bus.mode = 2'd0;
    tk(1);
    chk("step_start", bus.leds, 0);
    bus.step = 1'b1;
    t = 0;
    for (int i = 0; i < 5; i++) begin
      tk(1);
      t += int'(bus.tick);
      if (i == 0) chk("step_first_tick", bus.tick, 1);
    end
    chk("step_hold_ticks", t, 1);
    chk("step_hold_leds", bus.leds, 1);
    bus.step = 1'b0;
    tk(20);
    chk("pause_leds", bus.leds, 1);
    bus.step = 1'b1;
    tk(1);
    bus.step = 1'b0;
    chk("step2_leds", bus.leds, 2);
    tk(1);
    for (int i = 0; i < 800; i++) begin
      if ($urandom % 50 == 0) bus.mode = 2'($urandom % 4);
      if ($urandom % 25 == 0) bus.run = !bus.run;
      bus.step = ($urandom % 3) == 0;
      rst_n = ($urandom % 150) != 0;
      tk(1);
    end
    rst_n = 1'b1; bus.run = 1'b0; bus.step = 1'b0;
    tk(3);
    chk("sb_drain", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
